multi_debounce_scheduler: RTL and testbench

Debounces `N` asynchronous push-button/switch inputs using one shared sample-tick prescaler and one small per-channel tick counter instead of a full timer per channel. Each debounced edge becomes a one-byte event code. A round-robin arbiter serialises these codes onto a valid/ready port that feeds the UART TX FIFO write side. The block sits between board pins and the FIFO, and is the single owner of debounce timing in the design.

---
 rtl/multi_debounce_scheduler.sv | 240 ++++++++++++++++++++++++
 tb/tb_multi_debounce_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_debounce_scheduler.sv
// multi_debounce_scheduler
//
// Debounces N asynchronous button/switch inputs with one shared sample-tick
// prescaler and a small tick counter per channel. Every committed edge becomes
// an event byte (bit7 = press, bits[6:0] = channel) that a round-robin arbiter
// serialises onto a valid/ready output feeding the UART TX FIFO.
//
// Ports:
//   clk        rising-edge clock for all logic
//   reset_n    asynchronous active-low reset
//   noisy      raw asynchronous inputs, one per channel
//   debounce   registered debounced levels
//   evt_valid  event byte available in the output register
//   evt_ready  consumer accepts the byte when evt_valid & evt_ready
//   evt_code   event byte {press, channel[6:0]}
//   ovf        sticky flag: an event was dropped
//   ovf_clr    synchronous clear of ovf (a drop in the same cycle wins)
//   dbg_state  per-channel FSM state, 2 bits per channel (channel i at [2i+1:2i])
//
// Handshake: a byte moves on every rising edge where evt_valid & evt_ready.
// While evt_valid & !evt_ready, evt_code is held; evt_valid only drops after a
// transfer has emptied the register and nothing else is pending.

module multi_debounce_scheduler #(
    parameter int N            = 4,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 20
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   noisy,
    output logic [N-1:0]   debounce,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [7:0]     evt_code,
    output logic           ovf,
    input  logic           ovf_clr,
    output logic [2*N-1:0] dbg_state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam int LW = (N > 1) ? $clog2(N) : 1;

    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_TICKS - 1);
    localparam logic [LW-1:0] LAST_RST = LW'(N - 1);

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_ARM_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_ARM_LOW  = 2'd3
    } ch_state_t;

    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [PW-1:0] pre;
    logic          tick;

    ch_state_t     state [N];
    logic [CW-1:0] cnt   [N];

    logic [N-1:0]  rise;
    logic [N-1:0]  fall;
    logic [N-1:0]  raise;

    logic [N-1:0]  pend;
    logic [N-1:0]  pend_edge;
    logic [LW-1:0] last;

    logic          free;
    logic          grant_any;
    logic [LW-1:0] grant_idx;
    logic [N-1:0]  grant_vec;
    logic          drop_any;

    // Two-flop synchronizer; sync2 is the sampled level every FSM sees.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= noisy;
            sync2 <= sync1;
        end
    end

    // Shared prescaler: tick is high during the last count of each period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
        end else if (pre == PRE_MAX) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    assign tick = (pre == PRE_MAX);

    // Commit conditions: the armed level held through the final required tick.
    always_comb begin
        rise = '0;
        fall = '0;
        for (int i = 0; i < N; i++) begin
            rise[i] = (state[i] == ST_ARM_HIGH) && sync2[i] && tick && (cnt[i] == CNT_MAX);
            fall[i] = (state[i] == ST_ARM_LOW) && !sync2[i] && tick && (cnt[i] == CNT_MAX);
        end
        raise = rise | fall;
    end

    // Per-channel debounce FSMs. The bounce check has priority over the tick,
    // so a level that drops back in a tick cycle never counts that tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                state[i] <= ST_LOW;
                cnt[i]   <= '0;
            end
            debounce <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                case (state[i])
                    ST_LOW: begin
                        if (sync2[i]) begin
                            state[i] <= ST_ARM_HIGH;
                            cnt[i]   <= '0;
                        end
                    end
                    ST_ARM_HIGH: begin
                        if (!sync2[i]) begin
                            state[i] <= ST_LOW;
                        end else if (tick) begin
                            if (cnt[i] == CNT_MAX) begin
                                state[i]    <= ST_HIGH;
                                debounce[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt[i] + 1'b1;
                            end
                        end
                    end
                    ST_HIGH: begin
                        if (!sync2[i]) begin
                            state[i] <= ST_ARM_LOW;
                            cnt[i]   <= '0;
                        end
                    end
                    ST_ARM_LOW: begin
                        if (sync2[i]) begin
                            state[i] <= ST_HIGH;
                        end else if (tick) begin
                            if (cnt[i] == CNT_MAX) begin
                                state[i]    <= ST_LOW;
                                debounce[i] <= 1'b0;
                            end else begin
                                cnt[i] <= cnt[i] + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state[i] <= ST_LOW;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        dbg_state = '0;
        for (int i = 0; i < N; i++) begin
            dbg_state[2*i +: 2] = state[i];
        end
    end

    // Round-robin search starting just above the last granted channel.
    always_comb begin : arb
        int cand;
        cand      = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        free      = !evt_valid || evt_ready;
        for (int k = 1; k <= N; k++) begin
            cand = int'(last) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!grant_any && pend[LW'(cand)]) begin
                grant_any = 1'b1;
                grant_idx = LW'(cand);
            end
        end
        grant_vec = '0;
        for (int i = 0; i < N; i++) begin
            grant_vec[i] = free && grant_any && (grant_idx == LW'(i));
        end
        // A new edge is lost only when the old one is still waiting this cycle.
        drop_any = |(raise & pend & ~grant_vec);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend      <= '0;
            pend_edge <= '0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            ovf       <= 1'b0;
            last      <= LAST_RST;
        end else begin
            for (int i = 0; i < N; i++) begin
                // A grant frees the slot in the same cycle, so a colliding
                // new edge takes it over instead of being dropped.
                if (raise[i] && (!pend[i] || grant_vec[i])) begin
                    pend[i]      <= 1'b1;
                    pend_edge[i] <= rise[i];
                end else if (grant_vec[i]) begin
                    pend[i] <= 1'b0;
                end
            end

            if (drop_any) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

            if (free) begin
                if (grant_any) begin
                    evt_valid <= 1'b1;
                    evt_code  <= {pend_edge[grant_idx], 7'(grant_idx)};
                    last      <= grant_idx;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_debounce_scheduler.sv
// tb_multi_debounce_scheduler
//
// Bench for multi_debounce_scheduler with N=4, TICK_DIV=4, STABLE_TICKS=3.
// A reference model steps once per rising edge: debounce commits are derived
// from the edge index at which the synchronized level first differed from the
// debounced level and the number of tick instants seen since, and events are
// tracked as a pending set served in round-robin order. Directed scenarios are
// followed by a randomized phase; transferred bytes are matched against an
// expected queue filled by the model.

module tb_multi_debounce_scheduler;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int IW = $clog2(N);

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   noisy;
    logic [N-1:0]   debounce;
    logic           evt_valid;
    logic           evt_ready;
    logic [7:0]     evt_code;
    logic           ovf;
    logic           ovf_clr;
    logic [2*N-1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [N-1:0] m_s1;
    logic [N-1:0] m_s2;
    logic [N-1:0] m_deb;
    logic         m_pend [N];
    logic         m_edge [N];
    int           m_arm  [N];
    int           m_k;
    int           m_last;
    logic         m_valid;
    logic [7:0]   m_code;
    logic         m_ovf;

    logic [7:0] exp_q[$];
    logic [7:0] xfer_q[$];

    multi_debounce_scheduler #(
        .N(N),
        .TICK_DIV(TD),
        .STABLE_TICKS(ST)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .noisy(noisy),
        .debounce(debounce),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code(evt_code),
        .ovf(ovf),
        .ovf_clr(ovf_clr),
        .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1    = '0;
        m_s2    = '0;
        m_deb   = '0;
        m_k     = 0;
        m_last  = N - 1;
        m_valid = 1'b0;
        m_code  = '0;
        m_ovf   = 1'b0;
        for (int c = 0; c < N; c++) begin
            m_pend[c] = 1'b0;
            m_edge[c] = 1'b0;
            m_arm[c]  = -1;
        end
        exp_q.delete();
    endtask

    // Edge index k is a tick edge when k % TD == TD-1; the number of tick
    // edges in (a, k] is (k+1)/TD - (a+1)/TD.
    function automatic bit model_commit_next(input int c);
        return (m_s2[IW'(c)] != m_deb[IW'(c)]) && (m_arm[IW'(c)] >= 0) &&
               (((m_k + 1) / TD) - ((m_arm[IW'(c)] + 1) / TD) == ST);
    endfunction

    task automatic model_edge();
        logic [N-1:0] raise_v;
        logic [N-1:0] rise_v;
        bit           free;
        bit           drop;
        int           g;
        int           cc;
        raise_v = '0;
        rise_v  = '0;
        drop    = 1'b0;
        g       = -1;
        for (int c = 0; c < N; c++) begin
            if (m_s2[c] == m_deb[c]) begin
                m_arm[c] = -1;
            end else if (m_arm[c] < 0) begin
                m_arm[c] = m_k;
            end else if (((m_k + 1) / TD) - ((m_arm[c] + 1) / TD) == ST) begin
                raise_v[c] = 1'b1;
                rise_v[c]  = m_s2[c];
                m_deb[c]   = m_s2[c];
                m_arm[c]   = -1;
            end
        end
        free = !m_valid || evt_ready;
        if (free) begin
            for (int d = 1; d <= N; d++) begin
                cc = (m_last + d) % N;
                if (g < 0 && m_pend[IW'(cc)]) g = cc;
            end
            if (g >= 0) begin
                m_valid = 1'b1;
                m_code  = {m_edge[IW'(g)], 7'(g)};
                m_pend[IW'(g)] = 1'b0;
                m_last  = g;
                exp_q.push_back(m_code);
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int c = 0; c < N; c++) begin
            if (raise_v[c]) begin
                if (m_pend[c]) begin
                    drop = 1'b1;
                end else begin
                    m_pend[c] = 1'b1;
                    m_edge[c] = rise_v[c];
                end
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_s2 = m_s1;
        m_s1 = noisy;
        m_k++;
    endtask

    task automatic step();
        logic [7:0] e;
        if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
            check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("xfer_code", 32'(evt_code), 32'(e));
            end
            xfer_q.push_back(evt_code);
        end
        @(posedge clk);
        model_edge();
        #1;
        check("debounce", 32'(debounce), 32'(m_deb));
        check("evt_valid", 32'(evt_valid), 32'(m_valid));
        check("evt_code", 32'(evt_code), 32'(m_code));
        check("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    function automatic logic [31:0] packed_xfers();
        logic [31:0] v;
        v = '0;
        foreach (xfer_q[i]) v = {v[23:0], xfer_q[i]};
        return v;
    endfunction

    initial begin
        int  rise_n;
        int  vrise_n;
        bit  found;
        bit  seen_deb;
        bit  seen_valid;

        reset_n   = 1'b0;
        noisy     = '0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_debounce", 32'(debounce), 32'd0);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_code", 32'(evt_code), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        reset_n = 1'b1;
        model_reset();

        // Clean press and release on channel 0
        xfer_q.delete();
        noisy[0] = 1'b1;
        rise_n   = -1;
        vrise_n  = -1;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (rise_n < 0 && debounce[0] === 1'b1) rise_n = n;
            if (vrise_n < 0 && evt_valid === 1'b1) vrise_n = n;
        end
        check("s1_press_latency_in_9_12", 32'((rise_n - 3) >= 9 && (rise_n - 3) <= 12), 32'd1);
        check("s1_valid_after_debounce", 32'(vrise_n), 32'(rise_n + 1));
        noisy[0] = 1'b0;
        run(24);
        check("s1_xfer_count", 32'(xfer_q.size()), 32'd2);
        check("s1_xfer_seq", packed_xfers(), 32'h0000_8000);
        check("s1_ovf", 32'(ovf), 32'd0);

        // Bounce rejection on channel 2
        xfer_q.delete();
        seen_deb   = 1'b0;
        seen_valid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            noisy[2] = 1'b1;
            for (int n = 0; n < 5; n++) begin
                step();
                seen_deb   |= debounce[2];
                seen_valid |= evt_valid;
            end
            noisy[2] = 1'b0;
            for (int n = 0; n < 5; n++) begin
                step();
                seen_deb   |= debounce[2];
                seen_valid |= evt_valid;
            end
        end
        for (int n = 0; n < 20; n++) begin
            step();
            seen_deb   |= debounce[2];
            seen_valid |= evt_valid;
        end
        check("s2_debounce_stayed_low", 32'(seen_deb), 32'd0);
        check("s2_no_valid", 32'(seen_valid), 32'd0);
        check("s2_xfer_count", 32'(xfer_q.size()), 32'd0);

        // Round-robin: make channel 2 the last grant, then 1 and 3 together
        noisy[2] = 1'b1;
        run(20);
        xfer_q.delete();
        noisy[1] = 1'b1;
        noisy[3] = 1'b1;
        run(22);
        check("s3_press_count", 32'(xfer_q.size()), 32'd2);
        check("s3_press_order", packed_xfers(), 32'h0000_8381);
        xfer_q.delete();
        noisy[3:1] = 3'b000;
        run(22);
        check("s3_release_count", 32'(xfer_q.size()), 32'd3);
        check("s3_release_order", packed_xfers(), 32'h0002_0301);

        // Backpressure and overflow on channel 0
        xfer_q.delete();
        evt_ready = 1'b0;
        noisy[0]  = 1'b1;
        run(18);
        check("s4_valid_held", 32'(evt_valid), 32'd1);
        check("s4_code_press", 32'(evt_code), 32'h80);
        noisy[0] = 1'b0;
        run(18);
        check("s4_code_still_press", 32'(evt_code), 32'h80);
        check("s4_ovf_before_drop", 32'(ovf), 32'd0);
        noisy[0] = 1'b1;
        run(18);
        check("s4_ovf_set", 32'(ovf), 32'd1);
        check("s4_code_after_drop", 32'(evt_code), 32'h80);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("s4_ovf_cleared", 32'(ovf), 32'd0);
        evt_ready = 1'b1;
        run(6);
        check("s4_xfer_count", 32'(xfer_q.size()), 32'd2);
        check("s4_xfer_seq", packed_xfers(), 32'h0000_8000);
        check("s4_valid_idle", 32'(evt_valid), 32'd0);
        check("s4_debounce_high", 32'(debounce[0]), 32'd1);
        noisy[0] = 1'b0;
        run(22);

        // Grant of channel 1's pending release in the cycle its next press commits
        xfer_q.delete();
        evt_ready = 1'b0;
        noisy[1]  = 1'b1;
        run(18);
        noisy[1] = 1'b0;
        run(18);
        noisy[1] = 1'b1;
        found    = 1'b0;
        for (int n = 0; n < 24; n++) begin
            if (!found && model_commit_next(1)) begin
                evt_ready = 1'b1;
                found     = 1'b1;
            end
            step();
        end
        check("s5_collision_reached", 32'(found), 32'd1);
        evt_ready = 1'b1;
        run(6);
        check("s5_xfer_count", 32'(xfer_q.size()), 32'd3);
        check("s5_xfer_seq", packed_xfers(), 32'h0081_0181);
        check("s5_ovf", 32'(ovf), 32'd0);

        // Reset during ARM_HIGH with an event pending
        evt_ready = 1'b0;
        noisy[3]  = 1'b1;
        run(18);
        noisy[3] = 1'b0;
        run(18);
        noisy[0] = 1'b1;
        run(4);
        check("s6_pre_valid", 32'(evt_valid), 32'd1);
        check("s6_pre_debounce", 32'(debounce), 32'h2);
        #2;
        reset_n = 1'b0;
        #1;
        check("s6_rst_debounce", 32'(debounce), 32'd0);
        check("s6_rst_evt_valid", 32'(evt_valid), 32'd0);
        check("s6_rst_evt_code", 32'(evt_code), 32'd0);
        check("s6_rst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        evt_ready = 1'b1;
        xfer_q.delete();
        run(24);
        check("s6_xfer_count", 32'(xfer_q.size()), 32'd2);
        check("s6_xfer_seq", packed_xfers(), 32'h0000_8081);
        check("s6_debounce", 32'(debounce), 32'h3);

        // Randomized phase
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 11) == 0) noisy[c] = ~noisy[c];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            step();
        end
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        run(40);
        check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("final_valid_idle", 32'(evt_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
